// File: rtl/vlc_pkg.sv
// rtl/vlc_pkg.sv - shared widths, FSM encoding and length mask helper for the VLC bit packer.
package vlc_pkg;

  localparam int WORD_W     = 32;
  localparam int ACC_W      = 64;
  localparam int LEN_W      = 6;
  localparam int FILL_W     = 7;
  localparam int MAX_CW_LEN = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } vlc_state_e;

  // Keeps the low len bits; len==32 yields all ones.
  function automatic logic [WORD_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [ACC_W-1:0] m;
    m = (64'd1 << len) - 64'd1;
    return m[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/vlc_out_stage.sv
// rtl/vlc_out_stage.sv - single output word register with valid/ready hold.
module vlc_out_stage
  import vlc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic              load_last_i,
  input  logic              out_ready_i,
  output logic              slot_free_o,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_word_o,
  output logic              out_last_o
);

  logic              valid_q;
  logic [WORD_W-1:0] word_q;
  logic              last_q;

  assign slot_free_o = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_word_o  = word_q;
  assign out_last_o  = last_q;

  // The core only loads when slot_free_o is high, so a held word is never overwritten.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      word_q  <= load_word_i;
      last_q  <= load_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// rtl/vlc_bit_packer.sv - packs {codeword,length} pairs MSB-first into 32-bit words with flush.
// Optional bit_count output is built only when VLC_BITCOUNT_EN is defined.
module vlc_bit_packer
  import vlc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [WORD_W-1:0] cw_data,
  input  logic [31:0]       cw_length,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_last,
  output logic              flush_done,
  output logic              len_err
`ifdef VLC_BITCOUNT_EN
  ,
  output logic [31:0]       bit_count
`endif
);

  vlc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_ins;
  logic [FILL_W-1:0] fill_q, fill_d, fill_ins, shamt;
  logic              flush_done_q, flush_done_d;
  logic              len_err_q;
  logic              accept, len_legal, ins;
  logic [LEN_W-1:0]  len;
  logic [WORD_W-1:0] cw_masked;
  logic              slot_free, load, load_last;
  logic [WORD_W-1:0] load_word;

  assign cw_ready  = (state_q == ST_RUN) && (fill_q <= FILL_W'(WORD_W)) && !flush;
  assign accept    = cw_valid && cw_ready;
  assign len_legal = (cw_length <= 32'(MAX_CW_LEN));
  assign len       = cw_length[LEN_W-1:0];
  assign ins       = accept && len_legal && (len != '0);
  assign cw_masked = cw_data & len_mask(len);
  // Place the new code just below the bits already held; fill+len <= 64 whenever ins is high.
  assign shamt     = FILL_W'(ACC_W) - fill_q - {1'b0, len};
  assign acc_ins   = ins ? (acc_q | ({{WORD_W{1'b0}}, cw_masked} << shamt)) : acc_q;
  assign fill_ins  = ins ? (fill_q + {1'b0, len}) : fill_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_ins;
    fill_d       = fill_ins;
    flush_done_d = 1'b0;
    load         = 1'b0;
    load_last    = 1'b0;
    load_word    = acc_ins[ACC_W-1:WORD_W];
    case (state_q)
      ST_RUN: begin
        if (slot_free && fill_ins >= FILL_W'(WORD_W)) begin
          load   = 1'b1;
          acc_d  = acc_ins << WORD_W;
          fill_d = fill_ins - FILL_W'(WORD_W);
        end
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (slot_free) begin
          if (fill_q >= FILL_W'(WORD_W)) begin
            load   = 1'b1;
            acc_d  = acc_q << WORD_W;
            fill_d = fill_q - FILL_W'(WORD_W);
          end else if (fill_q != '0) begin
            // Unused low bits of the accumulator are already zero, giving the pad.
            load      = 1'b1;
            load_last = 1'b1;
            acc_d     = '0;
            fill_d    = '0;
          end else begin
            flush_done_d = 1'b1;
            state_d      = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= flush_done_d;
      if (accept && !len_legal) len_err_q <= 1'b1;
    end
  end

  assign flush_done = flush_done_q;
  assign len_err    = len_err_q;

`ifdef VLC_BITCOUNT_EN
  logic [31:0] bit_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_count_q <= '0;
    end else if (accept && len_legal) begin
      bit_count_q <= bit_count_q + cw_length;
    end
  end

  assign bit_count = bit_count_q;
`endif

  vlc_out_stage u_out_stage (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load),
    .load_word_i (load_word),
    .load_last_i (load_last),
    .out_ready_i (out_ready),
    .slot_free_o (slot_free),
    .out_valid_o (out_valid),
    .out_word_o  (out_word),
    .out_last_o  (out_last)
  );

endmodule
